// File: rtl/div_step_unit.sv
// Restoring-divider step slice: unsigned compare, subtract, select, and a
// loadable iteration counter whose terminal count is watched by the control FSM.
module div_step_unit #(
  parameter int WIDTH = 11,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] div,
  output logic             ge,
  output logic [WIDTH-1:0] diff,
  output logic [WIDTH-1:0] nxt_acc,
  output logic             q_bit,
  input  logic             cnt_up,
  input  logic             init_counter,
  input  logic [CNT_W-1:0] init_value,
  output logic [CNT_W-1:0] count,
  output logic             cout
);

  // Datapath is zero-latency; diff wraps when acc < div and is only consumed when ge=1.
  always_comb begin
    ge      = (acc >= div);
    diff    = acc - div;
    nxt_acc = ge ? diff : acc;
    q_bit   = ge;
  end

  // Priority: reset, then load, then increment, else hold.
  always_ff @(posedge clk) begin
    if (rst)               count <= '0;
    else if (init_counter) count <= init_value;
    else if (cnt_up)       count <= count + 1'b1;
  end

  assign cout = (count == {CNT_W{1'b1}});

endmodule

// File: tb/tb_div_step_unit.sv
// Directed bench for div_step_unit: integer reference model checked every cycle,
// plus hand-computed literal expectations.
module tb_div_step_unit;
  localparam int WIDTH = 11;
  localparam int CNT_W = 4;
  localparam int MOD   = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst, cnt_up, init_counter;
  logic [WIDTH-1:0] acc, div;
  logic [CNT_W-1:0] init_value;
  logic             ge, q_bit, cout;
  logic [WIDTH-1:0] diff, nxt_acc;
  logic [CNT_W-1:0] count;

  int errors = 0;
  int checks = 0;
  int m_count = 0;
  bit chk_en = 1'b0;

  div_step_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .acc(acc), .div(div), .ge(ge), .diff(diff),
    .nxt_acc(nxt_acc), .q_bit(q_bit), .cnt_up(cnt_up),
    .init_counter(init_counter), .init_value(init_value),
    .count(count), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference counter: plain integer arithmetic on the spec's priority rules.
  always @(posedge clk) begin
    if (rst)               m_count <= 0;
    else if (init_counter) m_count <= int'(init_value);
    else if (cnt_up)       m_count <= (m_count + 1) % 16;
  end

  // Cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      int a, b, d;
      a = int'(acc);
      b = int'(div);
      d = a - b;
      if (d < 0) d += MOD;
      check("m_ge",      32'(ge),      32'(a >= b));
      check("m_q_bit",   32'(q_bit),   32'(a >= b));
      check("m_diff",    32'(diff),    32'(d));
      check("m_nxt_acc", 32'(nxt_acc), (a >= b) ? 32'(d) : 32'(a));
      check("m_count",   32'(count),   32'(m_count));
      check("m_cout",    32'(cout),    32'(m_count == 15));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic comb(input int a, input int b, input int e_ge, input int e_diff, input int e_nxt);
    acc = WIDTH'(a);
    div = WIDTH'(b);
    #1;
    check("ge",      32'(ge),      32'(e_ge));
    check("q_bit",   32'(q_bit),   32'(e_ge));
    check("diff",    32'(diff),    32'(e_diff));
    check("nxt_acc", 32'(nxt_acc), 32'(e_nxt));
  endtask

  initial begin
    rst = 1'b1; cnt_up = 1'b0; init_counter = 1'b0; init_value = 4'd2;
    acc = '0; div = '0;
    tick();
    chk_en = 1'b1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_cout",  32'(cout),  32'd0);
    rst = 1'b0;

    // Datapath vectors
    comb(300, 100, 1, 200, 200);
    comb(5, 5, 1, 0, 0);
    comb(3, 7, 0, 'h7FC, 3);
    comb('h7FF, 0, 1, 'h7FF, 'h7FF);
    comb(0, 'h3FF, 0, 'h401, 0);

    // Load then count to terminal and wrap
    init_counter = 1'b1; tick(); init_counter = 1'b0;
    check("init_count", 32'(count), 32'd2);
    cnt_up = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      acc = WIDTH'($urandom_range(0, MOD - 1));
      div = WIDTH'($urandom_range(0, MOD - 1));
      tick();
      if (i == 12) check("cout_pre", 32'(cout), 32'd0);
    end
    check("term_count", 32'(count), 32'd15);
    check("term_cout",  32'(cout),  32'd1);
    tick();
    check("wrap_count", 32'(count), 32'd0);
    check("wrap_cout",  32'(cout),  32'd0);
    cnt_up = 1'b0;

    // Load beats increment from count 9
    init_counter = 1'b1; tick(); init_counter = 1'b0;
    cnt_up = 1'b1;
    repeat (7) tick();
    check("cnt9", 32'(count), 32'd9);
    init_counter = 1'b1; tick();
    check("init_over_up", 32'(count), 32'd2);

    // Reset beats both
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_over_all", 32'(count), 32'd0);
    init_counter = 1'b0;
    repeat (5) tick();
    cnt_up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold", 32'(count), 32'd5);
    end

    // Reset mid-count from 11
    init_counter = 1'b1; tick(); init_counter = 1'b0;
    cnt_up = 1'b1;
    repeat (9) tick();
    check("cnt11", 32'(count), 32'd11);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst", 32'(count), 32'd0);
    tick();
    check("resume", 32'(count), 32'd1);
    cnt_up = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
